// File: rtl/calc_disp_pkg.sv
// Shared types, segment patterns and sizing helper for the calculator result display.
package calc_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_E     = 7'b1111001;

    localparam logic [6:0] FONT_0 = 7'b0111111;
    localparam logic [6:0] FONT_1 = 7'b0000110;
    localparam logic [6:0] FONT_2 = 7'b1011011;
    localparam logic [6:0] FONT_3 = 7'b1001111;
    localparam logic [6:0] FONT_4 = 7'b1100110;
    localparam logic [6:0] FONT_5 = 7'b1101101;
    localparam logic [6:0] FONT_6 = 7'b1111101;
    localparam logic [6:0] FONT_7 = 7'b0000111;
    localparam logic [6:0] FONT_8 = 7'b1111111;
    localparam logic [6:0] FONT_9 = 7'b1101111;

    // Decimal digits needed to hold 2^width-1.
    function automatic int digits_for(input int width);
        logic [63:0] v;
        int          d;
        v = (64'd1 << width) - 64'd1;
        d = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/calc_result_display_seg7_encode.sv
// Maps one BCD nibble to a 7-segment pattern, with blanking and error override.
module seg7_encode
    import calc_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       err_digit,
    output logic [6:0] seg
);

    // Error wins over blanking, blanking wins over the font.
    always_comb begin
        seg = SEG_BLANK;
        if (err_digit) begin
            seg = SEG_E;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    seg = FONT_0;
                4'd1:    seg = FONT_1;
                4'd2:    seg = FONT_2;
                4'd3:    seg = FONT_3;
                4'd4:    seg = FONT_4;
                4'd5:    seg = FONT_5;
                4'd6:    seg = FONT_6;
                4'd7:    seg = FONT_7;
                4'd8:    seg = FONT_8;
                4'd9:    seg = FONT_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/calc_result_display.sv
// Captures result/error, converts to BCD by shift-add-3 and scans a
// multiplexed 7-segment display with leading-zero blanking.
module calc_result_display
    import calc_disp_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DIGITS   = 10,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      result,
    input  logic                  error,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [6:0]            seg
);

    localparam int NACC  = digits_for(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e                    state_q, state_d;
    logic [WIDTH-1:0]          shreg_q, shreg_d;
    logic [NACC*4-1:0]         acc_q, acc_d, acc_adj_s;
    logic [(NACC+DIGITS)*4-1:0] acc_ext_s;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_cap_q, err_cap_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [DIGITS*4-1:0]       bcd_q, bcd_d;
    logic                      err_q, err_d;
    logic [PRE_W-1:0]          pre_q, pre_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DIGITS-1:0]         digit_sel_q, digit_sel_d;
    logic [6:0]                seg_q, seg_d;
    logic [DIGITS*4-1:0]       shifted_s;
    logic                      blank_s;
    logic                      err_digit_s;

    // Add-3 correction applied to every accumulator nibble before each shift.
    always_comb begin
        acc_adj_s = acc_q;
        for (int i = 0; i < NACC; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_adj_s[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end else begin
                acc_adj_s[i*4 +: 4] = acc_q[i*4 +: 4];
            end
        end
    end

    // Zero-extend so a narrow accumulator can be committed into the full display width.
    assign acc_ext_s = {{(DIGITS*4){1'b0}}, acc_q};

    // Conversion FSM: next state, datapath and committed display value.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_cap_d = err_cap_q;
        bcd_d     = bcd_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d   = result;
                    err_cap_d = error;
                    acc_d     = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = CONV;
                end else begin
                    state_d   = IDLE;
                end
            end
            CONV: begin
                acc_d   = {acc_adj_s[NACC*4-2:0], shreg_q[WIDTH-1]};
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = COMMIT;
                end else begin
                    state_d = CONV;
                end
            end
            COMMIT: begin
                bcd_d   = acc_ext_s[DIGITS*4-1:0];
                err_d   = err_cap_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Free-running scan prescaler and digit index; seg is encoded for the next index
    // from the next committed value so digit_sel and seg always change together.
    always_comb begin
        pre_d = pre_q;
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
        digit_sel_d        = '0;
        digit_sel_d[idx_d] = 1'b1;
        shifted_s          = bcd_d >> {idx_d, 2'b00};
        blank_s            = (idx_d != '0) && (err_d || (shifted_s == '0));
        err_digit_s        = err_d && (idx_d == '0);
    end

    seg7_encode u_seg7_encode (
        .nibble    (shifted_s[3:0]),
        .blank     (blank_s),
        .err_digit (err_digit_s),
        .seg       (seg_d)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_cap_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bcd_q       <= '0;
            err_q       <= 1'b0;
            pre_q       <= '0;
            idx_q       <= '0;
            digit_sel_q <= DIGITS'(1);
            seg_q       <= FONT_0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_cap_q   <= err_cap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bcd_q       <= bcd_d;
            err_q       <= err_d;
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bcd       = bcd_q;
    assign digit_sel = digit_sel_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Directed, table-driven bench for calc_result_display.
module tb_calc_result_display;

    localparam int WIDTH    = 32;
    localparam int DIGITS   = 10;
    localparam int SCAN_DIV = 16;

    localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                           S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                           S6 = 7'b1111101, S7 = 7'b0000111, S8 = 7'b1111111,
                           S9 = 7'b1101111, SB = 7'b0000000, SE = 7'b1111001;

    logic                 clk;
    logic                 rst_n;
    logic                 load;
    logic [WIDTH-1:0]     result;
    logic                 error;
    logic                 busy;
    logic                 done;
    logic [DIGITS*4-1:0]  bcd;
    logic [DIGITS-1:0]    digit_sel;
    logic [6:0]           seg;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic [39:0] exp_bcd;
        logic [6:0]  exp_seg [10];
    } vec_t;

    vec_t vecs [5];
    logic [39:0] prev_bcd;

    calc_result_display #(
        .WIDTH    (WIDTH),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .result    (result),
        .error     (error),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .digit_sel (digit_sel),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observe one full scan cycle and compare every digit's pattern.
    task automatic check_scan(input int v);
        logic [6:0] seen_seg [10];
        bit         seen [10];
        int         bad_onehot;
        bad_onehot = 0;
        for (int i = 0; i < 10; i++) begin
            seen[i]     = 1'b0;
            seen_seg[i] = SB;
        end
        for (int c = 0; c < SCAN_DIV * DIGITS + 4; c++) begin
            @(negedge clk);
            if ($onehot(digit_sel)) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (digit_sel[i]) begin
                        seen[i]     = 1'b1;
                        seen_seg[i] = seg;
                    end
                end
            end else begin
                bad_onehot++;
            end
        end
        chk($sformatf("v%0d digit_sel onehot violations", v), 64'(bad_onehot), 64'd0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("v%0d digit%0d visited", v, i), 64'(seen[i]), 64'd1);
            chk($sformatf("v%0d digit%0d seg", v, i), 64'(seen_seg[i]), 64'(vecs[v].exp_seg[i]));
        end
    endtask

    // One load, latency/busy/done/bcd checks, then display checks.
    task automatic run_vec(input int v);
        int  n;
        int  busy_cnt;
        bit  got;
        @(negedge clk);
        load   = 1'b1;
        result = vecs[v].res;
        error  = vecs[v].err;
        @(posedge clk);
        #1;
        load   = 1'b0;
        result = 32'hDEAD_BEEF;
        error  = ~vecs[v].err;
        got = 1'b0;
        n = 0;
        busy_cnt = busy ? 1 : 0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(posedge clk);
            #1;
            if (c == 16) chk($sformatf("v%0d previous bcd held", v), 64'(bcd), 64'(prev_bcd));
            if (done) begin
                got = 1'b1;
                n   = c;
            end else if (busy) begin
                busy_cnt++;
            end
        end
        if (!got) begin
            chk($sformatf("v%0d done timeout", v), 64'd0, 64'd1);
        end else begin
            chk($sformatf("v%0d done latency", v), 64'(n), 64'd33);
            chk($sformatf("v%0d busy cycles", v), 64'(busy_cnt), 64'd33);
            chk($sformatf("v%0d busy at done", v), 64'(busy), 64'd0);
            chk($sformatf("v%0d bcd", v), 64'(bcd), 64'(vecs[v].exp_bcd));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d done single pulse", v), 64'(done), 64'd0);
        end
        prev_bcd = vecs[v].exp_bcd;
        check_scan(v);
    endtask

    initial begin
        int dn;
        int dn_at;

        vecs[0].res = 32'd382;      vecs[0].err = 1'b0; vecs[0].exp_bcd = 40'h00_0000_0382;
        vecs[0].exp_seg = '{S2, S8, S3, SB, SB, SB, SB, SB, SB, SB};
        vecs[1].res = 32'hFFFF_FFFF; vecs[1].err = 1'b0; vecs[1].exp_bcd = 40'h42_9496_7295;
        vecs[1].exp_seg = '{S5, S9, S2, S7, S6, S9, S4, S9, S2, S4};
        vecs[2].res = 32'd0;        vecs[2].err = 1'b1; vecs[2].exp_bcd = 40'h00_0000_0000;
        vecs[2].exp_seg = '{SE, SB, SB, SB, SB, SB, SB, SB, SB, SB};
        vecs[3].res = 32'd7;        vecs[3].err = 1'b0; vecs[3].exp_bcd = 40'h00_0000_0007;
        vecs[3].exp_seg = '{S7, SB, SB, SB, SB, SB, SB, SB, SB, SB};
        vecs[4].res = 32'd999;      vecs[4].err = 1'b0; vecs[4].exp_bcd = 40'h00_0000_0999;
        vecs[4].exp_seg = '{S9, S9, S9, SB, SB, SB, SB, SB, SB, SB};

        rst_n  = 1'b0;
        load   = 1'b0;
        result = '0;
        error  = 1'b0;
        prev_bcd = '0;

        // Reset state and idle scan advance.
        repeat (3) @(posedge clk);
        #1;
        chk("reset digit_sel", 64'(digit_sel), 64'd1);
        chk("reset seg", 64'(seg), 64'(S0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle busy", 64'(busy), 64'd0);
        chk("idle done", 64'(done), 64'd0);
        chk("idle bcd", 64'(bcd), 64'd0);
        repeat (SCAN_DIV - 1) @(posedge clk);
        #1;
        chk("scan before wrap digit_sel", 64'(digit_sel), 64'd1);
        @(posedge clk);
        #1;
        chk("scan after wrap digit_sel", 64'(digit_sel), 64'd2);
        chk("scan after wrap seg", 64'(seg), 64'(SB));

        for (int v = 0; v < 4; v++) run_vec(v);

        // A second load 6 edges into a conversion is ignored.
        @(negedge clk);
        load   = 1'b1;
        result = 32'd382;
        error  = 1'b0;
        @(posedge clk);
        #1;
        load = 1'b0;
        dn = 0;
        dn_at = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 6) begin
                load   = 1'b1;
                result = 32'd123;
            end else begin
                load = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                dn++;
                dn_at = c;
            end
        end
        load = 1'b0;
        chk("ignored load done count", 64'(dn), 64'd1);
        chk("ignored load done edge", 64'(dn_at), 64'd33);
        chk("ignored load bcd", 64'(bcd), 64'h382);

        // Reset in the middle of a conversion.
        @(negedge clk);
        load   = 1'b1;
        result = 32'd999;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset bcd", 64'(bcd), 64'd0);
        chk("midreset digit_sel", 64'(digit_sel), 64'd1);
        chk("midreset seg", 64'(seg), 64'(S0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) dn++;
        end
        chk("post-reset no activity", 64'(dn), 64'd0);
        prev_bcd = '0;
        run_vec(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
